// File: rtl/arriba_control_fsm.sv
// arriba_control_fsm
//   Control unit for the ABAJO_UNIT datapath. Sequences each instruction
//   through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK) and produces
//   the datapath control word, PC/stack/flag enables and the instruction,
//   data and port bus handshakes.
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   ClkEn_i                clock enable, 0 freezes all state
//   op_i, func_i           decoded instruction class and sub-op
//   carry_i, zero_i        registered ALU flags (used by branches)
//   inst/data/port_ack_i   bus acknowledges
//   inst/data/port_cyc_o   bus cycle strobes (at most one high at a time)
//   data_we_o, port_we_o   bus write enables
//   RegMux_o, RegWrt_o     writeback source / register write enable
//   op2_o, ALUOp_o         ALU operand-2 select / ALU function
//   flag_en_o              load carry/zero from ALU
//   pc_en_o, pc_mux_o      PC update strobe / next-PC source
//   push_o, pop_o          return stack control
//   halt_o                 core halted (left only by reset)
module arriba_control_fsm (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ClkEn_i,
  input  logic [2:0] op_i,
  input  logic [2:0] func_i,
  input  logic       carry_i,
  input  logic       zero_i,
  input  logic       inst_ack_i,
  input  logic       data_ack_i,
  input  logic       port_ack_i,
  output logic       inst_cyc_o,
  output logic       data_cyc_o,
  output logic       data_we_o,
  output logic       port_cyc_o,
  output logic       port_we_o,
  output logic [1:0] RegMux_o,
  output logic       RegWrt_o,
  output logic       op2_o,
  output logic [3:0] ALUOp_o,
  output logic       flag_en_o,
  output logic       pc_en_o,
  output logic [1:0] pc_mux_o,
  output logic       push_o,
  output logic       pop_o,
  output logic       halt_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_ALUI   = 3'b000;
  localparam logic [2:0] OP_ALUR   = 3'b001;
  localparam logic [2:0] OP_SHIFT  = 3'b010;
  localparam logic [2:0] OP_MEM    = 3'b011;
  localparam logic [2:0] OP_JUMP   = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [2:0] OP_MISC   = 3'b110;

  logic [2:0] state, state_nxt;
  logic [2:0] op_q, func_q;
  logic [3:0] alu_op_q;
  logic       op2_q;
  logic       inst_cyc_q, data_cyc_q, data_we_q, port_cyc_q, port_we_q;
  logic       mem_done, taken;
  logic       flag_en, pc_en, push, pop, reg_wrt;
  logic [1:0] pc_mux, reg_mux;

  // Acks only count while the matching strobe is up and the clock is enabled.
  assign mem_done = ClkEn_i && ((data_cyc_q && data_ack_i) || (port_cyc_q && port_ack_i));

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (ClkEn_i && inst_cyc_q && inst_ack_i) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ALUI, OP_ALUR, OP_SHIFT: state_nxt = S_WB;
          OP_MEM:  state_nxt = S_MEM;
          OP_MISC: state_nxt = (func_q == 3'b100 || func_q == 3'b101) ? S_HALT : S_FETCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      // stm/out complete straight to FETCH; ldm/inp go through writeback
      S_MEM:    if (mem_done) state_nxt = func_q[0] ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Bus strobes are registered from the next state, so the cycle right after
  // reset shows inst_cyc_o=0 even though the state is already FETCH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_FETCH;
      op_q       <= 3'b000;
      func_q     <= 3'b000;
      alu_op_q   <= 4'b0000;
      op2_q      <= 1'b0;
      inst_cyc_q <= 1'b0;
      data_cyc_q <= 1'b0;
      data_we_q  <= 1'b0;
      port_cyc_q <= 1'b0;
      port_we_q  <= 1'b0;
    end else if (ClkEn_i) begin
      state      <= state_nxt;
      inst_cyc_q <= (state_nxt == S_FETCH);
      data_cyc_q <= (state_nxt == S_MEM) && !func_q[1];
      data_we_q  <= (state_nxt == S_MEM) && !func_q[1] && func_q[0];
      port_cyc_q <= (state_nxt == S_MEM) && func_q[1];
      port_we_q  <= (state_nxt == S_MEM) && func_q[1] && func_q[0];
      if (state == S_DECODE) begin
        op_q   <= op_i;
        func_q <= func_i;
        case (op_i)
          OP_ALUI:  begin alu_op_q <= {1'b0, func_i};        op2_q <= 1'b0; end
          OP_ALUR:  begin alu_op_q <= {1'b0, func_i};        op2_q <= 1'b1; end
          OP_SHIFT: begin alu_op_q <= {2'b10, func_i[1:0]};  op2_q <= 1'b1; end
          default:  begin alu_op_q <= 4'b0000;               op2_q <= 1'b0; end
        endcase
      end
    end
  end

  always_comb begin
    case (func_q[1:0])
      2'b00:   taken = zero_i;
      2'b01:   taken = !zero_i;
      2'b10:   taken = carry_i;
      default: taken = !carry_i;
    endcase
  end

  always_comb begin
    flag_en = 1'b0;
    pc_en   = 1'b0;
    pc_mux  = 2'b00;
    push    = 1'b0;
    pop     = 1'b0;
    reg_wrt = 1'b0;
    reg_mux = 2'b00;
    case (state)
      S_EXEC: begin
        case (op_q)
          OP_ALUI, OP_ALUR, OP_SHIFT: flag_en = 1'b1;
          OP_MEM: ;
          OP_JUMP: begin
            pc_en  = 1'b1;
            pc_mux = 2'b10;
            push   = func_q[0];
          end
          OP_BRANCH: begin
            pc_en  = 1'b1;
            pc_mux = taken ? 2'b01 : 2'b00;
          end
          OP_MISC: begin
            if (func_q == 3'b000) begin
              pc_en  = 1'b1;
              pc_mux = 2'b11;
              pop    = 1'b1;
            end else if (func_q != 3'b100 && func_q != 3'b101) begin
              pc_en = 1'b1;
            end
          end
          default: pc_en = 1'b1;
        endcase
      end
      // stores/outputs advance the PC in the same cycle the ack arrives
      S_MEM: pc_en = mem_done && func_q[0];
      S_WB: begin
        reg_wrt = 1'b1;
        pc_en   = 1'b1;
        if (op_q == OP_MEM) reg_mux = func_q[1] ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign inst_cyc_o = inst_cyc_q;
  assign data_cyc_o = data_cyc_q;
  assign data_we_o  = data_we_q;
  assign port_cyc_o = port_cyc_q;
  assign port_we_o  = port_we_q;
  assign RegMux_o   = reg_mux;
  assign RegWrt_o   = reg_wrt;
  assign op2_o      = op2_q;
  assign ALUOp_o    = alu_op_q;
  assign flag_en_o  = flag_en;
  assign pc_en_o    = pc_en;
  assign pc_mux_o   = pc_mux;
  assign push_o     = push;
  assign pop_o      = pop;
  assign halt_o     = (state == S_HALT);

endmodule

// File: tb/tb_arriba_control_fsm.sv
// Testbench for arriba_control_fsm. Each scenario queues per-cycle stimulus
// with the expected control word, then plays the queue back and compares.
module tb_arriba_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, carry, zero, inst_ack, data_ack, port_ack;
  logic [2:0] op, func;
  logic       inst_cyc, data_cyc, data_we, port_cyc, port_we, reg_wrt, op2;
  logic       flag_en, pc_en, push, pop, halt;
  logic [1:0] reg_mux, pc_mux;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  arriba_control_fsm dut (
    .clk_i(clk), .rst_ni(rst_n), .ClkEn_i(clk_en), .op_i(op), .func_i(func),
    .carry_i(carry), .zero_i(zero), .inst_ack_i(inst_ack), .data_ack_i(data_ack),
    .port_ack_i(port_ack), .inst_cyc_o(inst_cyc), .data_cyc_o(data_cyc),
    .data_we_o(data_we), .port_cyc_o(port_cyc), .port_we_o(port_we),
    .RegMux_o(reg_mux), .RegWrt_o(reg_wrt), .op2_o(op2), .ALUOp_o(alu_op),
    .flag_en_o(flag_en), .pc_en_o(pc_en), .pc_mux_o(pc_mux), .push_o(push),
    .pop_o(pop), .halt_o(halt)
  );

  typedef struct packed {
    logic inst_cyc, data_cyc, data_we, port_cyc, port_we;
    logic [1:0] reg_mux;
    logic reg_wrt, op2;
    logic [3:0] alu_op;
    logic flag_en, pc_en;
    logic [1:0] pc_mux;
    logic push, pop, halt;
  } cw_t;

  typedef struct packed {
    logic rst_n, en;
    logic [2:0] op, func;
    logic c, z, ia, da, pa;
  } stim_t;

  stim_t sq[$];
  cw_t   eq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic [3:0] cur_alu = 4'b0000;
  logic       cur_op2 = 1'b0;

  function automatic cw_t obs();
    obs = '{inst_cyc, data_cyc, data_we, port_cyc, port_we, reg_mux, reg_wrt, op2,
            alu_op, flag_en, pc_en, pc_mux, push, pop, halt};
  endfunction

  function automatic cw_t base();
    cw_t e = '0;
    e.alu_op = cur_alu;
    e.op2    = cur_op2;
    return e;
  endfunction

  function automatic stim_t st(input logic [2:0] o, input logic [2:0] f,
                               input logic c, input logic z);
    stim_t s = '0;
    s.rst_n = 1'b1; s.en = 1'b1; s.op = o; s.func = f; s.c = c; s.z = z;
    return s;
  endfunction

  task automatic push_cyc(input stim_t s, input cw_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    rst_n = s.rst_n; clk_en = s.en; op = s.op; func = s.func;
    carry = s.c; zero = s.z; inst_ack = s.ia; data_ack = s.da; port_ack = s.pa;
  endtask

  // Fetch (with fw wait cycles), decode and execute of one instruction.
  task automatic gen_fde(input logic [2:0] o, input logic [2:0] f,
                         input logic c, input logic z, input int fw);
    stim_t s;
    cw_t   e;
    logic  tk;
    s = st(o, f, c, z);
    for (int i = 0; i <= fw; i++) begin
      s.ia = (i == fw);
      e = base(); e.inst_cyc = 1'b1;
      push_cyc(s, e);
    end
    s.ia = 1'b0;
    push_cyc(s, base());
    case (o)
      3'b000:  begin cur_alu = {1'b0, f};       cur_op2 = 1'b0; end
      3'b001:  begin cur_alu = {1'b0, f};       cur_op2 = 1'b1; end
      3'b010:  begin cur_alu = {2'b10, f[1:0]}; cur_op2 = 1'b1; end
      default: begin cur_alu = 4'b0000;         cur_op2 = 1'b0; end
    endcase
    e = base();
    case (o)
      3'b000, 3'b001, 3'b010: e.flag_en = 1'b1;
      3'b011: ;
      3'b100: begin e.pc_en = 1'b1; e.pc_mux = 2'b10; e.push = f[0]; end
      3'b101: begin
        tk = (f[1:0] == 2'b00) ? z : (f[1:0] == 2'b01) ? !z : (f[1:0] == 2'b10) ? c : !c;
        e.pc_en = 1'b1; e.pc_mux = tk ? 2'b01 : 2'b00;
      end
      3'b110: begin
        if (f == 3'b000) begin e.pc_en = 1'b1; e.pc_mux = 2'b11; e.pop = 1'b1; end
        else if (f != 3'b100 && f != 3'b101) e.pc_en = 1'b1;
      end
      default: e.pc_en = 1'b1;
    endcase
    push_cyc(s, e);
  endtask

  // Whole instruction; n = memory cycles including the ack cycle.
  task automatic gen_instr(input logic [2:0] o, input logic [2:0] f,
                           input logic c, input logic z, input int fw, input int n);
    stim_t s;
    cw_t   e;
    gen_fde(o, f, c, z, fw);
    s = st(o, f, c, z);
    if (o == 3'b011) begin
      for (int i = 0; i < n; i++) begin
        s.da = (i == n - 1) && !f[1];
        s.pa = (i == n - 1) && f[1];
        e = base();
        e.data_cyc = !f[1]; e.port_cyc = f[1];
        e.data_we = !f[1] && f[0]; e.port_we = f[1] && f[0];
        e.pc_en = (i == n - 1) && f[0];
        push_cyc(s, e);
      end
      s.da = 1'b0; s.pa = 1'b0;
    end
    if (o <= 3'b010 || (o == 3'b011 && !f[0])) begin
      e = base(); e.reg_wrt = 1'b1; e.pc_en = 1'b1;
      if (o == 3'b011) e.reg_mux = f[1] ? 2'b10 : 2'b01;
      push_cyc(s, e);
    end
  endtask

  task automatic test_reset();
    stim_t s;
    cw_t   e;
    int    k;
    s = st(3'b011, 3'b000, 1'b0, 1'b0);
    s.rst_n = 1'b0;
    drive(s);
    repeat (2) @(posedge clk);
    #1;
    cur_alu = 4'b0000; cur_op2 = 1'b0;
    push_cyc(st(3'b011, 3'b000, 1'b0, 1'b0), '0);       // first cycle out of reset
    gen_fde(3'b011, 3'b000, 1'b0, 1'b0, 0);             // ldm up to EXECUTE
    s = st(3'b011, 3'b000, 1'b0, 1'b0);
    e = base(); e.data_cyc = 1'b1;
    push_cyc(s, e);                                     // MEM, no ack
    s.rst_n = 1'b0;
    push_cyc(s, e);                                     // reset seen at end of this cycle
    push_cyc(s, '0);                                    // second reset cycle: already FETCH
    s.rst_n = 1'b1;
    push_cyc(s, '0);                                    // first cycle out of reset
    cur_alu = 4'b0000; cur_op2 = 1'b0;
    k = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h, want %h", k, obs(), e);
      end
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu_and_mem();
    cw_t e;
    int  k;
    gen_instr(3'b001, 3'b010, 1'b0, 1'b0, 0, 0);        // ALU-reg, ALUOp 0010, op2 1
    gen_instr(3'b000, 3'b111, 1'b0, 1'b0, 2, 0);        // ALU-imm with fetch wait
    gen_instr(3'b010, 3'b110, 1'b0, 1'b0, 0, 0);        // shift -> ALUOp 1010
    gen_instr(3'b011, 3'b000, 1'b0, 1'b0, 0, 3);        // ldm, 3 data cycles
    gen_instr(3'b011, 3'b001, 1'b0, 1'b0, 0, 1);        // stm, ack same cycle
    gen_instr(3'b011, 3'b010, 1'b0, 1'b0, 0, 2);        // inp
    gen_instr(3'b011, 3'b011, 1'b0, 1'b0, 0, 1);        // out
    k = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL alu_mem[%0d]: got %h, want %h", k, obs(), e);
      end
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flow();
    cw_t e;
    int  k;
    gen_instr(3'b101, 3'b000, 1'b0, 1'b1, 0, 0);        // bz taken
    gen_instr(3'b101, 3'b000, 1'b0, 1'b0, 0, 0);        // bz not taken
    gen_instr(3'b101, 3'b001, 1'b0, 1'b0, 0, 0);        // bnz taken
    gen_instr(3'b101, 3'b010, 1'b1, 1'b0, 0, 0);        // bc taken
    gen_instr(3'b101, 3'b011, 1'b1, 1'b0, 0, 0);        // bnc not taken
    gen_instr(3'b100, 3'b001, 1'b0, 1'b0, 0, 0);        // jsb
    gen_instr(3'b100, 3'b000, 1'b0, 1'b0, 0, 0);        // jmp
    gen_instr(3'b110, 3'b000, 1'b0, 1'b0, 0, 0);        // ret
    gen_instr(3'b110, 3'b010, 1'b0, 1'b0, 0, 0);        // misc NOP
    k = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL flow[%0d]: got %h, want %h", k, obs(), e);
      end
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    cw_t e;
    int  k;
    logic [2:0] o, f;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      f = 3'($urandom_range(0, 7));
      if (o == 3'b110 && (f == 3'b100 || f == 3'b101)) f = 3'b001;
      gen_instr(o, f, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(1, 3));
    end
    k = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %h, want %h", k, obs(), e);
      end
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_freeze_halt();
    stim_t s;
    cw_t   e;
    int    k;
    s = st(3'b001, 3'b011, 1'b0, 1'b0);
    s.en = 1'b0; s.ia = 1'b1;
    e = base(); e.inst_cyc = 1'b1;
    repeat (5) push_cyc(s, e);                          // frozen FETCH ignores ack
    gen_instr(3'b001, 3'b011, 1'b0, 1'b0, 0, 0);
    gen_fde(3'b110, 3'b101, 1'b0, 1'b0, 0);             // stby
    s = st(3'b110, 3'b101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s.ia = i[0]; s.da = i[1]; s.pa = 1'b1;
      e = base(); e.halt = 1'b1;
      push_cyc(s, e);
    end
    s = st(3'b000, 3'b000, 1'b0, 1'b0);
    s.rst_n = 1'b0;
    push_cyc(s, e);                                     // still halted until the edge
    s.rst_n = 1'b1;
    push_cyc(s, '0);
    cur_alu = 4'b0000; cur_op2 = 1'b0;
    e = '0; e.inst_cyc = 1'b1;
    push_cyc(s, e);                                     // fetch resumes
    k = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL freeze_halt[%0d]: got %h, want %h", k, obs(), e);
      end
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_and_mem();
    test_flow();
    test_back_to_back();
    test_freeze_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
